hp_div: RTL
===========

HP_DIV -- requirements
Module: hp_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; accepted only when busy=0.
REQ-004 SHALL have ports a and b, input, 16 bits each: IEEE 754 binary16 dividend and divisor; sampled only in the accept cycle.
REQ-005 SHALL have port busy, output, 1 bit: high from the cycle after accept until done.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse; q and flags are valid in that cycle.
REQ-007 SHALL have port q, output, 16 bits: binary16 quotient a/b.
REQ-008 SHALL have ports snan, qnan, infinity, zero, subnormal, normal, output, 1 bit each: result class; exactly one is high while a result is held.

Function
REQ-009 SHALL be a FSM with states IDLE, DIVIDE, NORM, DONE.
- IDLE: on start, go to DONE if the operation is a special case, else to DIVIDE.
- DIVIDE: exactly 13 cycles, then NORM.
- NORM: 1 cycle, then DONE.
- DONE: 1 cycle with done=1, then IDLE.
REQ-010 SHALL use a fixed latency from the accept edge to the done pulse: 2 cycles for a special case, 16 cycles for the arithmetic path.
REQ-011 SHALL ignore start while busy=1; queued requests are not retained.
REQ-012 SHALL hold q and flags stable from done until the next done pulse, including across a new start.
REQ-013 SHALL compute the quotient sign as a[15]^b[15] for every non-NaN result.
REQ-014 SHALL resolve special cases in priority order:
- either operand sNaN: q = that operand (a first), snan=1.
- else either operand qNaN: q = that operand (a first), qnan=1.
- else inf/inf or 0/0: q = {sign,5'h1F,10'h200}, qnan=1.
- else a=inf or b=0: q = {sign,5'h1F,10'h0}, infinity=1.
- else a=0 or b=inf: q = {sign,15'h0}, zero=1.
REQ-015 SHALL, on the arithmetic path, obtain unbiased exponents and 11-bit significands with explicit leading 1 from the converter; subnormal operands arrive normalised.
REQ-016 SHALL perform restoring division: one quotient bit per DIVIDE cycle, 13 bits total (1 integer, 12 fractional), 12-bit partial remainder; sticky = OR of the final remainder.
REQ-017 SHALL compute the exponent in 7-bit signed form as expA-expB; in NORM, if quotient bit 12 is 0, shift left 1 and decrement the exponent.
REQ-018 SHALL map the result by biased exponent e = exp+15:
- e >= 31: infinity.
- e <= 0: flush to signed zero, zero=1.
- otherwise: normal, q = {sign, e[4:0], quotient[10:1] after rounding}.
REQ-019 SHALL, when rounding increments the significand past 11 bits, renormalise and increment e; a resulting e = 31 gives infinity.

Reset
REQ-020 SHALL, on rst, force state=IDLE, busy=0, done=0, q=16'h0, all flags 0; this takes effect in any state and aborts a division in progress with no done pulse.
REQ-021 SHALL ignore start in a cycle where rst=1.

Configuration
REQ-022 SHALL support macro HP_DIV_ROUND_EN:
- defined: round-to-nearest-even using the guard bit (quotient[0]) and sticky.
- undefined: truncate toward zero; guard and sticky are discarded and latency is unchanged.

Structure
REQ-023 SHALL place the FSM state enum, binary16 field widths, bias constant 15, and the canonical qNaN/inf/zero encodings in a shared package, e.g. hp_pkg.
REQ-024 SHALL instantiate the existing converter sub-module twice, once each for a and b; no other sub-module.

Verification
REQ-025 SHALL cover: a=3C00, b=3C00, start -> done at +16, q=3C00, normal=1.
REQ-026 SHALL cover: a=3C00, b=4200 -> q=3555, normal=1, both with and without HP_DIV_ROUND_EN.
REQ-027 SHALL cover: a=4000, b=0000 -> done at +2, q=7C00, infinity=1; a=0000, b=0000 -> q=7E00, qnan=1.
REQ-028 SHALL cover: a=7BFF, b=0400 -> q=7C00, infinity=1; a=0400, b=7BFF -> q=0000, zero=1.
REQ-029 SHALL cover: a=7D00 (sNaN), b=3C00 -> q=7D00, snan=1; start pulsed while busy -> no extra done.
REQ-030 SHALL cover: rst asserted at cycle 8 of DIVIDE -> outputs cleared, no done; a new start then completes normally.

Source files
------------

// File: rtl/hp_div_pkg.sv
// Shared definitions for the binary16 divider: field widths, exponent bias,
// FSM state encodings, result-class bundle and canonical special encodings.
package hp_div_pkg;

    localparam int HP_W      = 16;  // binary16 word
    localparam int EXP_W     = 5;   // exponent field
    localparam int MAN_W     = 10;  // stored mantissa field
    localparam int SIG_W     = 11;  // significand with explicit leading 1
    localparam int EXP_BIAS  = 15;
    localparam int DIV_STEPS = 13;  // 1 integer + 12 fractional quotient bits

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_NORM   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Magnitude (bits 14:0) of the canonical special results; sign is prepended
    localparam logic [14:0] QNAN_MAG = 15'h7E00;
    localparam logic [14:0] INF_MAG  = 15'h7C00;
    localparam logic [14:0] ZERO_MAG = 15'h0000;

    // Result class, one-hot while a result is held
    typedef struct packed {
        logic snan;
        logic qnan;
        logic infinity;
        logic zero;
        logic subnormal;
        logic normal;
    } class_t;

    localparam class_t CLS_NONE   = 6'b000000;
    localparam class_t CLS_SNAN   = 6'b100000;
    localparam class_t CLS_QNAN   = 6'b010000;
    localparam class_t CLS_INF    = 6'b001000;
    localparam class_t CLS_ZERO   = 6'b000100;
    localparam class_t CLS_NORMAL = 6'b000001;

endpackage

// File: rtl/hp_div_unpack.sv
// Binary16 operand converter: classifies the operand and produces an unbiased
// exponent plus an 11-bit significand with explicit leading 1. Subnormal
// inputs are normalised here so the divider only ever sees 1.xxx values.
module hp_div_unpack
    import hp_div_pkg::*;
(
    input  logic [HP_W-1:0]   x,
    output logic              isSnan,
    output logic              isQnan,
    output logic              isInf,
    output logic              isZero,
    output logic signed [6:0] expUnb,
    output logic [SIG_W-1:0]  sig
);

    logic [EXP_W-1:0] expField;
    logic [MAN_W-1:0] man;
    logic [3:0]       lead;
    logic [3:0]       shift;

    assign expField = x[14:10];
    assign man      = x[9:0];

    assign isSnan = (expField == 5'h1F) && (man != '0) && !man[9];
    assign isQnan = (expField == 5'h1F) && man[9];
    assign isInf  = (expField == 5'h1F) && (man == '0);
    assign isZero = (expField == '0) && (man == '0);

    // Leading-one search and normalisation of subnormal mantissas
    always_comb begin
        lead = 4'd0;
        for (int i = 0; i < MAN_W; i++) begin
            if (man[i]) lead = 4'(i);
        end
        shift = 4'd10 - lead;
        if (expField == '0) begin
            sig    = {1'b0, man} << shift;
            expUnb = 7'(1 - EXP_BIAS) - $signed({3'b000, shift});
        end else begin
            sig    = {1'b1, man};
            expUnb = $signed({2'b00, expField}) - 7'(EXP_BIAS);
        end
    end

endmodule

// File: rtl/hp_div.sv
// Multi-cycle binary16 divider (restoring, one quotient bit per cycle).
// Special operands resolve straight to DONE; the arithmetic path runs
// 13 DIVIDE cycles and one NORM cycle. DONE is the commit cycle: q, the
// class flags and the done pulse are registered out of it, so done shows
// up 2 cycles after accept for a special case and 16 for arithmetic.
// Handshake: start is taken only in IDLE (busy=0) and never while rst=1;
// busy stays high until the result commits; done is a single-cycle pulse
// and q/flags then hold until the next commit.
// Optional macro HP_DIV_ROUND_EN: round-to-nearest-even (default truncates).
module hp_div
    import hp_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [HP_W-1:0] a,
    input  logic [HP_W-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [HP_W-1:0] q,
    output logic            snan,
    output logic            qnan,
    output logic            infinity,
    output logic            zero,
    output logic            subnormal,
    output logic            normal,
    output logic [1:0]      dbgState
);

    logic                aSnan, aQnan, aInf, aZero;
    logic                bSnan, bQnan, bInf, bZero;
    logic signed [6:0]   aExp, bExp;
    logic [SIG_W-1:0]    aSig, bSig;

    logic [1:0]          state;
    logic [3:0]          stepCnt;
    logic                sign;
    logic signed [6:0]   expQ;
    logic [SIG_W-1:0]    divisor;
    logic [11:0]         rem;
    logic [12:0]         quo;
    logic [HP_W-1:0]     pendQ;
    class_t              pendCls;
    class_t              outCls;

    logic                qSign;
    logic                isSpecial;
    logic [HP_W-1:0]     specQ;
    class_t              specCls;

    logic [12:0]         trial;
    logic                qBit;
    logic [11:0]         remKeep;

    logic [12:0]         normQuo;
    logic signed [6:0]   normExp;
    logic signed [6:0]   biasedExp;
    logic signed [6:0]   eRound;
    logic                roundUp;
    logic [11:0]         rounded;
    logic [9:0]          fracR;
    logic [HP_W-1:0]     arithQ;
    class_t              arithCls;

    hp_div_unpack uA (
        .x(a), .isSnan(aSnan), .isQnan(aQnan), .isInf(aInf), .isZero(aZero),
        .expUnb(aExp), .sig(aSig)
    );

    hp_div_unpack uB (
        .x(b), .isSnan(bSnan), .isQnan(bQnan), .isInf(bInf), .isZero(bZero),
        .expUnb(bExp), .sig(bSig)
    );

    assign qSign = a[15] ^ b[15];

    // Special-case resolution in priority order; NaN operands pass through
    always_comb begin
        specQ     = '0;
        specCls   = CLS_NONE;
        isSpecial = 1'b1;
        if (aSnan) begin
            specQ = a;  specCls = CLS_SNAN;
        end else if (bSnan) begin
            specQ = b;  specCls = CLS_SNAN;
        end else if (aQnan) begin
            specQ = a;  specCls = CLS_QNAN;
        end else if (bQnan) begin
            specQ = b;  specCls = CLS_QNAN;
        end else if ((aInf && bInf) || (aZero && bZero)) begin
            specQ = {qSign, QNAN_MAG};  specCls = CLS_QNAN;
        end else if (aInf || bZero) begin
            specQ = {qSign, INF_MAG};   specCls = CLS_INF;
        end else if (aZero || bInf) begin
            specQ = {qSign, ZERO_MAG};  specCls = CLS_ZERO;
        end else begin
            isSpecial = 1'b0;
        end
    end

    // One restoring step: subtract divisor if it fits, keep remainder otherwise
    always_comb begin
        trial   = {1'b0, rem} - {2'b00, divisor};
        qBit    = ~trial[12];
        remKeep = qBit ? trial[11:0] : rem;
    end

    // Normalise, round and map the quotient to a binary16 result
    always_comb begin
        normQuo   = quo[12] ? quo : {quo[11:0], 1'b0};
        normExp   = quo[12] ? expQ : expQ - 7'sd1;
        biasedExp = normExp + 7'(EXP_BIAS);
`ifdef HP_DIV_ROUND_EN
        // guard = normQuo[1], sticky = normQuo[0] | remainder, lsb = normQuo[2]
        roundUp   = normQuo[1] & (normQuo[0] | (|rem) | normQuo[2]);
`else
        roundUp   = 1'b0;
`endif
        rounded   = {1'b0, normQuo[12:2]} + {11'd0, roundUp};
        fracR     = rounded[11] ? rounded[10:1] : rounded[9:0];
        eRound    = rounded[11] ? biasedExp + 7'sd1 : biasedExp;
        if (biasedExp <= 7'sd0) begin
            arithQ   = {sign, ZERO_MAG};
            arithCls = CLS_ZERO;
        end else if (eRound >= 7'sd31) begin
            arithQ   = {sign, INF_MAG};
            arithCls = CLS_INF;
        end else begin
            arithQ   = {sign, eRound[4:0], fracR};
            arithCls = CLS_NORMAL;
        end
    end

`ifndef HP_DIV_ROUND_EN
    // Guard and sticky bits are intentionally discarded when truncating
    logic unusedRoundBits;
    assign unusedRoundBits = ^normQuo[1:0];
`endif

    // Control FSM and divider datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            stepCnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign    <= qSign;
                        expQ    <= aExp - bExp;
                        divisor <= bSig;
                        rem     <= {1'b0, aSig};
                        quo     <= '0;
                        stepCnt <= '0;
                        pendQ   <= specQ;
                        pendCls <= specCls;
                        state   <= isSpecial ? ST_DONE : ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    rem <= remKeep << 1;
                    quo <= {quo[11:0], qBit};
                    if (stepCnt == 4'(DIV_STEPS - 1)) state <= ST_NORM;
                    else stepCnt <= stepCnt + 4'd1;
                end
                ST_NORM: begin
                    pendQ   <= arithQ;
                    pendCls <= arithCls;
                    state   <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result commit: outputs change only when leaving DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            q      <= '0;
            outCls <= CLS_NONE;
        end else begin
            done <= (state == ST_DONE);
            if (state == ST_DONE) begin
                q      <= pendQ;
                outCls <= pendCls;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbgState  = state;
    assign snan      = outCls.snan;
    assign qnan      = outCls.qnan;
    assign infinity  = outCls.infinity;
    assign zero      = outCls.zero;
    assign subnormal = outCls.subnormal;
    assign normal    = outCls.normal;

endmodule
